// File: rtl/dct_pkg.sv
// Shared definitions for the DCT zigzag reader: stream FSM states and the
// JPEG zigzag scan tables mapping scan position k to (row, col) of an 8x8 block.
package dct_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_t;

    localparam logic [2:0] ZZ_ROW [64] = '{
        3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
        3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
        3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7,
        3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
        3'd5, 3'd6, 3'd7, 3'd7
    };

    localparam logic [2:0] ZZ_COL [64] = '{
        3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0,
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1,
        3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
        3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
        3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd3,
        3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd5, 3'd6,
        3'd7, 3'd7, 3'd6, 3'd7
    };

endpackage

// File: rtl/dct_zz_addr_gen.sv
// Zigzag scan address generator: 6-bit scan position that advances on each
// accepted coefficient and wraps 63 -> 0, plus its (row, col) lookup.
module dct_zz_addr_gen
    import dct_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [5:0] idx,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic [5:0] cnt_r;

    // Scan position register; natural 6-bit wrap carries 63 back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 6'd0;
        end else if (advance) begin
            cnt_r <= cnt_r + 6'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign idx  = cnt_r;
    assign row  = ZZ_ROW[cnt_r];
    assign col  = ZZ_COL[cnt_r];
    assign last = (cnt_r == 6'd63);

endmodule

// File: rtl/dct_zigzag_reader.sv
// Double-buffered 8x8 block reader: captures column-stage blocks into two
// register banks and streams them out in zigzag order with valid/ready.
module dct_zigzag_reader
    import dct_pkg::*;
#(
    parameter int SIZE_IN = 12,
    parameter int NBANK   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [SIZE_IN-1:0] blk_in [7:0][7:0],
    input  logic                      blk_valid,
    output logic                      blk_ready,
    output logic signed [SIZE_IN-1:0] coef_out,
    output logic [5:0]                coef_idx,
    output logic                      coef_valid,
    input  logic                      coef_ready,
    output logic                      coef_last,
    output logic                      overflow
);

    logic signed [SIZE_IN-1:0] bank0_r [7:0][7:0];
    logic signed [SIZE_IN-1:0] bank1_r [7:0][7:0];
    logic [NBANK-1:0]          full_r;
    logic [NBANK-1:0]          full_s;
    logic                      rd_ptr_r;
    logic                      rd_ptr_s;
    logic                      blk_ready_r;
    logic                      overflow_r;
    stream_state_t             state_r;
    stream_state_t             state_s;
    logic                      capture_s;
    logic                      transfer_s;
    logic                      release_s;
    logic                      wr_sel_s;
    logic [5:0]                idx_s;
    logic [2:0]                row_s;
    logic [2:0]                col_s;
    logic                      last_s;
    logic signed [SIZE_IN-1:0] coef_sel_s;

    // The bank that is free: bank 0 unless it already holds a block.
    assign wr_sel_s   = full_r[0];
    assign capture_s  = blk_valid & blk_ready_r;
    assign transfer_s = (state_r == ST_STREAM) & coef_ready;
    assign release_s  = transfer_s & last_s;

    dct_zz_addr_gen u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .advance (transfer_s),
        .idx     (idx_s),
        .row     (row_s),
        .col     (col_s),
        .last    (last_s)
    );

    // Next bank flags, read pointer and stream state.
    always_comb begin
        full_s   = full_r;
        rd_ptr_s = rd_ptr_r;
        state_s  = state_r;
        if (release_s) begin
            full_s[rd_ptr_r] = 1'b0;
            rd_ptr_s         = ~rd_ptr_r;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        if (capture_s) begin
            full_s[wr_sel_s] = 1'b1;
        end else begin
            full_s = full_s;
        end
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    state_s  = ST_STREAM;
                    rd_ptr_s = wr_sel_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // A capture landing in the other bank this cycle keeps the stream gapless.
                if (release_s) begin
                    state_s = full_s[~rd_ptr_r] ? ST_STREAM : ST_IDLE;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state, registered blk_ready and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r      <= {NBANK{1'b0}};
            rd_ptr_r    <= 1'b0;
            state_r     <= ST_IDLE;
            blk_ready_r <= 1'b1;
            overflow_r  <= 1'b0;
        end else begin
            full_r      <= full_s;
            rd_ptr_r    <= rd_ptr_s;
            state_r     <= state_s;
            blk_ready_r <= ~&full_s;
            if (blk_valid && !blk_ready_r) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Block storage; contents are meaningless once their full flag is clear.
    always_ff @(posedge clk) begin
        if (!rst && capture_s && !wr_sel_s) begin
            bank0_r <= blk_in;
        end else if (!rst && capture_s && wr_sel_s) begin
            bank1_r <= blk_in;
        end else begin
            bank0_r <= bank0_r;
            bank1_r <= bank1_r;
        end
    end

    assign coef_sel_s = rd_ptr_r ? bank1_r[col_s][row_s] : bank0_r[col_s][row_s];

    assign coef_valid = (state_r == ST_STREAM);
    assign coef_out   = coef_valid ? coef_sel_s : {SIZE_IN{1'b0}};
    assign coef_idx   = idx_s;
    assign coef_last  = coef_valid & last_s;
    assign blk_ready  = blk_ready_r;
    assign overflow   = overflow_r;

endmodule

// File: doc/dct_zigzag_reader.md
DCT_ZIGZAG_READER -- requirements
Module: dct_zigzag_reader

Interface
REQ-001 SHALL have parameter SIZE_IN, default 12, giving the signed width of each input coefficient (the column-stage output width).
REQ-002 SHALL have parameter NBANK, default 2, giving the number of 8x8 block buffers; only the value 2 is supported.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 blk_in  input  signed [SIZE_IN-1:0] [7:0][7:0]  8x8 block, indexed [col][row]; sampled only when blk_valid=1.
REQ-006 blk_valid  input  1  single-cycle pulse marking blk_in as a complete block (the column-stage done pulse).
REQ-007 blk_ready  output  1  at least one bank is free; registered.
REQ-008 coef_out  output  signed [SIZE_IN-1:0]  current coefficient in zigzag scan order.
REQ-009 coef_idx  output  6  zigzag scan position (0..63) of coef_out.
REQ-010 coef_valid  output  1  coef_out, coef_idx and coef_last are valid.
REQ-011 coef_ready  input  1  downstream accepts; a transfer occurs when coef_valid=1 and coef_ready=1 in the same cycle.
REQ-012 coef_last  output  1  high with coef_idx=63.
REQ-013 overflow  output  1  sticky; set when a block is dropped.

Function
REQ-014 SHALL capture blk_in into a free bank on the rising edge where blk_valid=1 and blk_ready=1; when both banks are free, bank 0 is used.
REQ-015 SHALL drop the block and set overflow when blk_valid=1 and blk_ready=0; banks and the stream are unaffected.
REQ-016 SHALL compute blk_ready from registered bank-full flags only; a bank released in the same cycle does not make that cycle's blk_valid acceptable.
REQ-017 Stream FSM states: IDLE (no full bank, coef_valid=0) and STREAM (coef_valid=1).
REQ-018 IDLE->STREAM on the edge after a capture; the first coefficient (idx 0) is presented in the cycle after blk_valid (latency 1).
REQ-019 SHALL output banks in capture order; a bank is released, and its full flag cleared, on the transfer with coef_last=1.
REQ-020 coef_out SHALL equal bank[ZZ_COL[k]][ZZ_ROW[k]] for k=coef_idx, using the standard JPEG zigzag order (k0=(r0,c0), k1=(r0,c1), k2=(r1,c0), k3=(r2,c0), ...).
REQ-021 The scan counter SHALL advance by 1 only on a transfer; while coef_valid=1 and coef_ready=0, all coef_* outputs hold stable.
REQ-022 After the last transfer: if the other bank is full, SHALL stay in STREAM and present idx 0 of that bank the next cycle (no bubble); otherwise go to IDLE.
REQ-023 A simultaneous capture and last transfer SHALL both take effect; the counter wraps from 63 to 0.
REQ-024 coef_out SHALL be a pure selection with no arithmetic or width change; coefficient values pass through unaltered.
REQ-025 overflow SHALL clear only on rst.

Reset
REQ-026 On rst: both banks empty, FSM=IDLE, scan counter=0, read-bank pointer=0, write-bank pointer=0.
REQ-027 Output reset values: coef_valid=0, coef_out=0, coef_idx=0, coef_last=0, blk_ready=1, overflow=0.
REQ-028 rst mid-stream SHALL abandon the buffered blocks; no further coefficients from them are output.
REQ-029 blk_valid coincident with rst SHALL be ignored.

Structure
REQ-030 The shared package dct_pkg SHALL hold the 64-entry ZZ_ROW and ZZ_COL constant tables and the FSM state typedef.
REQ-031 Sub-module dct_zz_addr_gen SHALL contain the 6-bit scan counter, the advance/wrap logic and the (row,col) lookup.
REQ-032 Bank storage and the mux SHALL remain in dct_zigzag_reader; no memories are inferred, only registers.

Verification
REQ-033 Single block with blk_in[c][r]=8*r+c, coef_ready=1: outputs 0,1,8,16,9,2,3,10,... 63 on consecutive cycles, starting the cycle after blk_valid; coef_last=1 only with value 63.
REQ-034 Same block, coef_ready toggling 1,0,1,0: 64 transfers in order; outputs held stable during ready=0 cycles.
REQ-035 Two blocks 2 cycles apart (block B = 100+8r+c), ready=1: 128 contiguous valid cycles with B's 100 immediately following A's 63; blk_ready=0 after the second capture.
REQ-036 Third blk_valid while both banks are full: block dropped; overflow=1 and remains 1; A and B stream intact.
REQ-037 rst asserted at coef_idx=20: the next cycle shows coef_valid=0, blk_ready=1, overflow=0; a new block then streams from idx 0.
REQ-038 Negative data (all coefficients -2048 at SIZE_IN=12): 64 outputs of -2048, verifying the sign is preserved.
